// File: rtl/keys_pkg.sv
// rtl/keys_pkg.sv - shared constants and event-word layout for the key event scanner
// KEY_EVENT_TIMESTAMP_EN adds a 16-bit tick stamp above the state bit.
package keys_pkg;

  localparam int KEYS_DEFAULT  = 61;
  localparam int IDX_W         = 6;
  localparam int TS_W          = 16;

  localparam int EVT_IDX_LSB   = 0;
  localparam int EVT_STATE_BIT = IDX_W;
  localparam int EVT_TS_LSB    = IDX_W + 1;

`ifdef KEY_EVENT_TIMESTAMP_EN
  localparam int EVT_W = IDX_W + 1 + TS_W;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic             state;
    logic [IDX_W-1:0] idx;
  } evt_t;
`else
  localparam int EVT_W = IDX_W + 1;

  typedef struct packed {
    logic             state;
    logic [IDX_W-1:0] idx;
  } evt_t;
`endif

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - show-ahead synchronous event FIFO with occupancy count
// Head data reads as zero while empty.
module key_evt_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             valid_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign valid_o    = (level_q != '0);
  assign do_push    = push_i & ~full_o & ~flush_i;
  assign do_pop     = pop_i & valid_o & ~flush_i;
  assign pop_data_o = valid_o ? mem[rd_ptr_q] : '0;
  assign level_o    = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scanner.sv
// rtl/key_event_scanner.sv - round-robin key scan with change events queued to the host
// KEY_EVENT_TIMESTAMP_EN prefixes each event with a free-running 16-bit tick stamp.
module key_event_scanner #(
  parameter int KEYS       = keys_pkg::KEYS_DEFAULT,
  parameter int IDX_W      = keys_pkg::IDX_W,
  parameter int FIFO_DEPTH = 8,
`ifdef KEY_EVENT_TIMESTAMP_EN
  localparam int EVT_W     = IDX_W + 1 + keys_pkg::TS_W,
`else
  localparam int EVT_W     = IDX_W + 1,
`endif
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [KEYS-1:0]  keys_i,
  input  logic             scan_en_i,
  input  logic             flush_i,
  output logic [EVT_W-1:0] evt_data_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             scan_wrap_o
);

  import keys_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEYS - 1);

  logic [IDX_W-1:0] idx_q;
  logic [KEYS-1:0]  shadow_q;
  logic             wrap_q;
  logic             fifo_full;
  logic             cur_key;
  logic             diff;
  logic             scan_go;
  logic             do_push;
  logic             advance;
  logic [EVT_W-1:0] push_data;

  assign cur_key = keys_i[idx_q];
  assign diff    = cur_key ^ shadow_q[idx_q];
  assign scan_go = scan_en_i & ~flush_i;
  assign do_push = scan_go & diff & ~fifo_full;
  // A changed key with no room holds the scan so the event is never lost.
  assign advance = scan_go & (~diff | ~fifo_full);

`ifdef KEY_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  assign push_data = {ts_q, cur_key, idx_q};
`else
  assign push_data = {cur_key, idx_q};
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q    <= '0;
      shadow_q <= '1;
      wrap_q   <= 1'b0;
    end else if (flush_i) begin
      idx_q    <= '0;
      shadow_q <= keys_i;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= advance && (idx_q == LAST_IDX);
      if (do_push) shadow_q[idx_q] <= cur_key;
      if (advance) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  assign scan_wrap_o = wrap_q;

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .push_i      (do_push),
    .push_data_i (push_data),
    .full_o      (fifo_full),
    .pop_i       (evt_ready_i),
    .pop_data_o  (evt_data_o),
    .valid_o     (evt_valid_o),
    .level_o     (fifo_level_o)
  );

endmodule

// File: tb/tb_key_event_scanner.sv
// tb/tb_key_event_scanner.sv - directed bench for key_event_scanner
// Timestamp checks are included when KEY_EVENT_TIMESTAMP_EN is defined.
module tb_key_event_scanner;
  import keys_pkg::*;

  localparam int KEYS = 61;
  localparam int LW   = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [KEYS-1:0]  keys_i;
  logic             scan_en_i;
  logic             flush_i;
  logic [EVT_W-1:0] evt_data_o;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [LW-1:0]    fifo_level_o;
  logic             scan_wrap_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  key_event_scanner dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .keys_i       (keys_i),
    .scan_en_i    (scan_en_i),
    .flush_i      (flush_i),
    .evt_data_o   (evt_data_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .fifo_level_o (fifo_level_o),
    .scan_wrap_o  (scan_wrap_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_flush(input logic rdy);
    flush_i     = 1'b1;
    evt_ready_i = rdy;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; keys_i = '1; scan_en_i = 1'b0; flush_i = 1'b0; evt_ready_i = 1'b0;
    #12;
    vectors++; if (evt_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", evt_valid_o); end
    vectors++; if (evt_data_o !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", evt_data_o); end
    vectors++; if (fifo_level_o !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
    vectors++; if (scan_wrap_o !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b expected 0", scan_wrap_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_idle_scan();
    int wraps = 0, first = -1, last = -1, valid_seen = 0;
    scan_en_i = 1'b1; evt_ready_i = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (evt_valid_o) valid_seen++;
      if (scan_wrap_o) begin
        wraps++;
        if (first < 0) first = t;
        else begin
          vectors++;
          if (t - last != 61) begin miscompares++; $display("FAIL wrap_period: got %0d expected 61", t - last); end
        end
        last = t;
      end
    end
    vectors++; if (valid_seen != 0) begin miscompares++; $display("FAIL idle_no_events: got %0d expected 0", valid_seen); end
    vectors++; if (wraps != 3) begin miscompares++; $display("FAIL idle_wrap_count: got %0d expected 3", wraps); end
    vectors++; if (first != 61) begin miscompares++; $display("FAIL idle_first_wrap: got %0d expected 61", first); end
  endtask

  task automatic test_single_key();
    int n, at;
    logic [6:0] d;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin do_flush(1'b1); keys_i[5] = 1'b0; end
      else keys_i[5] = 1'b1;
      n = 0; at = -1; d = '0;
      for (int t = 1; t <= 61; t++) begin
        tick();
        if (evt_valid_o) begin n++; at = t; d = evt_data_o[6:0]; end
      end
      vectors++; if (n != 1) begin miscompares++; $display("FAIL key5_count[%0d]: got %0d expected 1", pass, n); end
      vectors++; if (d !== (pass == 0 ? 7'h05 : 7'h45)) begin miscompares++; $display("FAIL key5_data[%0d]: got %h expected %h", pass, d, (pass == 0 ? 7'h05 : 7'h45)); end
      vectors++; if (at != 6) begin miscompares++; $display("FAIL key5_cycle[%0d]: got %0d expected 6", pass, at); end
    end
  endtask

  task automatic test_fill_stall();
    logic [6:0] got[$];
    do_flush(1'b0);
    keys_i[9:0] = '0;
    for (int t = 0; t < 20; t++) tick();
    vectors++; if (fifo_level_o !== 4'd8) begin miscompares++; $display("FAIL fill_level: got %0d expected 8", fifo_level_o); end
    vectors++; if (evt_data_o[6:0] !== 7'h00) begin miscompares++; $display("FAIL fill_head: got %h expected 00", evt_data_o[6:0]); end
    evt_ready_i = 1'b1;
    if (evt_valid_o) got.push_back(evt_data_o[6:0]);
    tick();
    evt_ready_i = 1'b0;
    vectors++; if (fifo_level_o !== 4'd7) begin miscompares++; $display("FAIL full_pop_level: got %0d expected 7", fifo_level_o); end
    tick();
    vectors++; if (fifo_level_o !== 4'd8) begin miscompares++; $display("FAIL retry_push_level: got %0d expected 8", fifo_level_o); end
    evt_ready_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (evt_valid_o) got.push_back(evt_data_o[6:0]);
      tick();
    end
    vectors++; if (got.size() != 10) begin miscompares++; $display("FAIL drain_count: got %0d expected 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      vectors++; if (got[i] !== 7'(i)) begin miscompares++; $display("FAIL drain_order[%0d]: got %h expected %h", i, got[i], 7'(i)); end
    end
    vectors++; if (fifo_level_o !== 4'd0) begin miscompares++; $display("FAIL drain_final_level: got %0d expected 0", fifo_level_o); end
  endtask

  task automatic test_flush();
    int n = 0;
    do_flush(1'b0);
    keys_i[2:0] = 3'b111;
    for (int t = 0; t < 3; t++) tick();
    vectors++; if (fifo_level_o !== 4'd3) begin miscompares++; $display("FAIL preflush_level: got %0d expected 3", fifo_level_o); end
    keys_i[7:5] = 3'b000;
    do_flush(1'b1);
    vectors++; if (fifo_level_o !== 4'd0) begin miscompares++; $display("FAIL flush_level: got %0d expected 0", fifo_level_o); end
    vectors++; if (evt_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", evt_valid_o); end
    keys_i[0] = 1'b0;
    tick();
    vectors++; if (evt_valid_o !== 1'b1 || evt_data_o[6:0] !== 7'h00) begin miscompares++; $display("FAIL flush_idx_restart: got valid %b data %h expected 1 00", evt_valid_o, evt_data_o[6:0]); end
    for (int t = 0; t < 70; t++) begin tick(); if (evt_valid_o) n++; end
    vectors++; if (n != 0) begin miscompares++; $display("FAIL flush_absorbs_changes: got %0d expected 0", n); end
  endtask

  task automatic test_scan_disable();
    int nv = 0, nw = 0;
    do_flush(1'b1);
    scan_en_i = 1'b0; evt_ready_i = 1'b0;
    keys_i[1] = 1'b0;
    for (int t = 0; t < 70; t++) begin tick(); if (evt_valid_o) nv++; if (scan_wrap_o) nw++; end
    vectors++; if (nv != 0) begin miscompares++; $display("FAIL disabled_no_push: got %0d expected 0", nv); end
    vectors++; if (nw != 0) begin miscompares++; $display("FAIL disabled_no_wrap: got %0d expected 0", nw); end
    scan_en_i = 1'b1;
    tick(); tick();
    vectors++; if (evt_valid_o !== 1'b1 || evt_data_o[6:0] !== 7'h01) begin miscompares++; $display("FAIL resume_event: got valid %b data %h expected 1 01", evt_valid_o, evt_data_o[6:0]); end
    scan_en_i = 1'b0; evt_ready_i = 1'b1;
    tick();
    vectors++; if (fifo_level_o !== 4'd0) begin miscompares++; $display("FAIL disabled_drain: got %0d expected 0", fifo_level_o); end
  endtask

  task automatic test_async_reset();
    do_flush(1'b0);
    scan_en_i = 1'b1;
    keys_i[3:0] = ~keys_i[3:0];
    for (int t = 0; t < 4; t++) tick();
    vectors++; if (fifo_level_o !== 4'd4) begin miscompares++; $display("FAIL prereset_level: got %0d expected 4", fifo_level_o); end
    #2 rst_n_i = 1'b0;
    #1;
    vectors++; if (fifo_level_o !== 4'd0 || evt_valid_o !== 1'b0 || evt_data_o !== '0) begin miscompares++; $display("FAIL async_reset: got level %0d valid %b data %h expected 0 0 0", fifo_level_o, evt_valid_o, evt_data_o); end
    keys_i = '1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

`ifdef KEY_EVENT_TIMESTAMP_EN
  task automatic wait_evt(input string name, output logic [15:0] ts);
    evt_t e;
    bit ok = 0;
    ts = '0;
    for (int t = 0; t < 70 && !ok; t++) begin
      tick();
      if (evt_valid_o) begin e = evt_t'(evt_data_o); ts = e.ts; ok = 1; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_timeout: got no event expected one within 70 cycles", name); end
  endtask

  task automatic test_timestamp();
    logic [15:0] a, b, c, d;
    do_flush(1'b1);
    scan_en_i = 1'b1;
    keys_i[0] = 1'b0;
    wait_evt("ts_first", a);
    for (int t = 0; t < 1000; t++) tick();
    keys_i[0] = 1'b1;
    wait_evt("ts_second", b);
    d = b - a;
    vectors++; if (d < 16'd939 || d > 16'd1061) begin miscompares++; $display("FAIL ts_delta: got %0d expected 1000+-61", d); end
    for (int t = 0; t < 65536; t++) tick();
    keys_i[0] = 1'b0;
    wait_evt("ts_third", c);
    d = c - b;
    vectors++; if (d < 16'd1 || d > 16'd61) begin miscompares++; $display("FAIL ts_rollover: got %0d expected 1..61", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_fill_stall();
    test_flush();
    test_scan_disable();
    test_async_reset();
`ifdef KEY_EVENT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
